// File: rtl/alu_multicycle_pkg.sv
// Shared operation codes and FSM state encoding for alu_multicycle.
// ST_HCF exists only when ALU_HCF_EN is defined.
package alu_multicycle_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_HCF = 4'b1001;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
`ifdef ALU_HCF_EN
  localparam state_t ST_HCF  = 2'd2;
`endif
  localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/alu_hcf_unit.sv
// Binary (Stein) GCD engine, one step per cycle; o_done is combinational so the
// parent can register the result on the same edge the answer becomes known.
module alu_hcf_unit #(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  logic               r_busy;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic [SHAMT_W-1:0] r_k;
  logic               w_term;
  logic [XLEN-1:0]    w_base;

  // Zero operand or equal operands end the iteration; common factors of two are restored via r_k.
  assign w_term   = (r_a == '0) || (r_b == '0) || (r_a == r_b);
  assign w_base   = (r_a == '0) ? r_b : r_a;
  assign o_done   = r_busy && w_term;
  assign o_result = w_base << r_k;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_k    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_a    <= i_a;
      r_b    <= i_b;
      r_k    <= '0;
    end else if (r_busy) begin
      if (w_term) begin
        r_busy <= 1'b0;
      end else begin
        case ({r_a[0], r_b[0]})
          2'b00: begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + SHAMT_W'(1);
          end
          2'b01:   r_a <= r_a >> 1;
          2'b10:   r_b <= r_b >> 1;
          default: begin
            if (r_a > r_b) r_a <= (r_a - r_b) >> 1;
            else           r_b <= (r_b - r_a) >> 1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops, shift-add MUL, optional HCF.
// Define ALU_HCF_EN to include the GCD unit; otherwise code 1001 is illegal.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int SHAMT_W = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic            regwrite_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            regwrite_out,
  output logic [4:0]      rd_out,
  output logic            illegal
);

  state_t             r_state;
  logic [XLEN-1:0]    r_result;
  logic               r_regwrite;
  logic [4:0]         r_rd;
  logic               r_illegal;
  logic [XLEN-1:0]    r_mcand;
  logic [XLEN-1:0]    r_mplier;
  logic [XLEN-1:0]    r_acc;
  logic [SHAMT_W-1:0] r_cnt;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_single;
  logic [XLEN-1:0]    w_acc_next;

  assign in_ready     = (r_state == ST_IDLE);
  assign out_valid    = (r_state == ST_DONE);
  assign result       = r_result;
  assign regwrite_out = r_regwrite;
  assign rd_out       = r_rd;
  assign illegal      = r_illegal;

  assign w_accept   = in_valid && in_ready;
  assign w_shamt    = op_b[SHAMT_W-1:0];
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    // NOTE: default assignment first so no case path leaves w_single unassigned and infers a latch.
    w_single = '0;
    case (alu_control)
      ALU_AND: w_single = op_a & op_b;
      ALU_OR:  w_single = op_a | op_b;
      ALU_ADD: w_single = op_a + op_b;
      ALU_SLL: w_single = op_a << w_shamt;
      ALU_SRL: w_single = op_a >> w_shamt;
      ALU_XOR: w_single = op_a ^ op_b;
      default: w_single = '0;
    endcase
  end

`ifdef ALU_HCF_EN
  logic            w_hcf_start;
  logic            w_hcf_done;
  logic [XLEN-1:0] w_hcf_result;

  assign w_hcf_start = w_accept && (alu_control == ALU_HCF);

  alu_hcf_unit #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_hcf (
    .clock    (clock),
    .reset    (reset),
    .i_start  (w_hcf_start),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_done   (w_hcf_done),
    .o_result (w_hcf_result)
  );
`endif

  // NOTE: state updates use <= so every branch below sees the pre-edge register values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_result   <= '0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_illegal  <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_rd       <= rd_in;
            r_regwrite <= regwrite_in;
            r_illegal  <= 1'b0;
            case (alu_control)
              ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_XOR: begin
                r_result <= w_single;
                r_state  <= ST_DONE;
              end
              ALU_MUL: begin
                r_mcand  <= op_a;
                r_mplier <= op_b;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_state  <= ST_MUL;
              end
`ifdef ALU_HCF_EN
              ALU_HCF: r_state <= ST_HCF;
`endif
              default: begin
                r_result   <= '0;
                r_regwrite <= 1'b0;
                r_illegal  <= 1'b1;
                r_state    <= ST_DONE;
              end
            endcase
          end
        end
        ST_MUL: begin
          // The XLEN-th iteration lands directly in r_result on the DONE transition.
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(XLEN - 1)) begin
            r_result <= w_acc_next;
            r_state  <= ST_DONE;
          end
        end
`ifdef ALU_HCF_EN
        ST_HCF: begin
          if (w_hcf_done) begin
            r_result <= w_hcf_result;
            r_state  <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: stimulus pushes expectations, a monitor
// pops and compares on out_valid. HCF expectations follow ALU_HCF_EN.
module tb_alu_multicycle;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic        regwrite_in;
  logic [4:0]  rd_in;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        regwrite_out;
  logic [4:0]  rd_out;
  logic        illegal;

  alu_multicycle #(.XLEN(64), .SHAMT_W(6)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_control  (alu_control),
    .regwrite_in  (regwrite_in),
    .rd_in        (rd_in),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .regwrite_out (regwrite_out),
    .rd_out       (rd_out),
    .illegal      (illegal)
  );

  typedef struct {
    logic [63:0] res;
    logic        rw;
    logic [4:0]  rd;
    logic        ill;
    int          lat_min;
    int          lat_max;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   bp_hold = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%h expected=0x%h", name, got, exp);
    end
  endtask

  // Present one operation, wait (bounded) for acceptance, record the expectation.
  task automatic issue(input logic [3:0] code, input logic rw, input logic [4:0] rd,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input logic exp_ill,
                       input int lat_min, input int lat_max);
    exp_t e;
    int   n;
    @(negedge clock);
    alu_control = code;
    regwrite_in = rw;
    rd_in       = rd;
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      if (out_valid) check("in_ready_while_done", in_ready, 0);
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e.res     = exp_res;
    e.rw      = rw & ~exp_ill;
    e.rd      = rd;
    e.ill     = exp_ill;
    e.lat_min = lat_min;
    e.lat_max = lat_max;
    e.acc_cyc = cyc + 1;
    q.push_back(e);
    @(posedge clock);
    #1;
    // Scramble inputs after accept; the DUT must have captured its own copy.
    in_valid    = 1'b0;
    alu_control = 4'b0010;
    regwrite_in = ~rw;
    rd_in       = ~rd;
    op_a        = ~a;
    op_b        = b + 64'd1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 1000) check("drain_timeout", q.size(), 0);
  endtask

  // Monitor: compare on first sight of out_valid, then check hold stability.
  exp_t cur;
  bit   mon_busy = 0;
  bit   mon_have = 0;
  int   hold_left = 0;

  initial begin
    int lat;
    out_ready = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_busy  = 0;
        out_ready = 1'b1;
      end else if (out_valid) begin
        if (!mon_busy) begin
          mon_busy = 1;
          if (q.size() == 0) begin
            mon_have  = 0;
            hold_left = 0;
            check("spurious_out_valid", out_valid, 0);
          end else begin
            mon_have = 1;
            cur = q.pop_front();
            check("result", result, cur.res);
            check("regwrite_out", regwrite_out, cur.rw);
            check("rd_out", rd_out, cur.rd);
            check("illegal", illegal, cur.ill);
            lat = cyc - cur.acc_cyc + 1;
            checks++;
            if (lat < cur.lat_min || lat > cur.lat_max) begin
              errors++;
              $display("FAIL latency: got=%0d expected=%0d..%0d", lat, cur.lat_min, cur.lat_max);
            end
            hold_left = bp_hold;
            bp_hold   = 0;
          end
        end else if (mon_have) begin
          check("hold_result", result, cur.res);
          check("hold_rd_out", rd_out, cur.rd);
          check("hold_in_ready", in_ready, 0);
        end
        out_ready = (hold_left == 0);
        if (hold_left > 0) hold_left--;
      end else begin
        mon_busy  = 0;
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    int seen;
    reset       = 1'b1;
    in_valid    = 1'b0;
    alu_control = 4'b0;
    regwrite_in = 1'b0;
    rd_in       = 5'd0;
    op_a        = 64'd0;
    op_b        = 64'd0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_regwrite", regwrite_out, 0);
    check("rst_rd", rd_out, 0);
    check("rst_illegal", illegal, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Single-cycle operations
    issue(4'b0010, 1'b1, 5'd5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1, 1);
    issue(4'b0000, 1'b1, 5'd1,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
          64'hF000_F000_F000_F000, 1'b0, 1, 1);
    issue(4'b0001, 1'b0, 5'd2,  64'h1234_0000_0000_0000, 64'h0000_0000_0000_5678,
          64'h1234_0000_0000_5678, 1'b0, 1, 1);
    issue(4'b0111, 1'b1, 5'd3,  64'hFFFF_0000_FFFF_0000, 64'hFF00_FF00_FF00_FF00,
          64'h00FF_FF00_00FF_FF00, 1'b0, 1, 1);
    issue(4'b0011, 1'b1, 5'd4,  64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1, 1);
    issue(4'b0011, 1'b1, 5'd6,  64'd3, 64'h41, 64'd6, 1'b0, 1, 1);
    issue(4'b0101, 1'b1, 5'd7,  64'h8000_0000_0000_0000, 64'd63, 64'd1, 1'b0, 1, 1);
    issue(4'b0101, 1'b1, 5'd8,  64'hF000_0000_0000_0000, 64'd4,
          64'h0F00_0000_0000_0000, 1'b0, 1, 1);

    // Multiply
    issue(4'b0110, 1'b1, 5'd9,  64'h1_0000_0001, 64'd3, 64'h3_0000_0003, 1'b0, 65, 65);
    issue(4'b0110, 1'b1, 5'd10, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b0, 65, 65);
    issue(4'b0110, 1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd1, 1'b0, 65, 65);

    // Illegal code
    issue(4'b1111, 1'b1, 5'd12, 64'd123, 64'd456, 64'd0, 1'b1, 1, 1);

    // GCD (or illegal when the feature is compiled out)
`ifdef ALU_HCF_EN
    issue(4'b1001, 1'b1, 5'd13, 64'd48, 64'd18, 64'd6, 1'b0, 2, 130);
    issue(4'b1001, 1'b1, 5'd14, 64'd0, 64'd7, 64'd7, 1'b0, 1, 2);
    issue(4'b1001, 1'b1, 5'd15, 64'd5, 64'd0, 64'd5, 1'b0, 1, 2);
    issue(4'b1001, 1'b1, 5'd16, 64'd0, 64'd0, 64'd0, 1'b0, 1, 2);
    issue(4'b1001, 1'b1, 5'd17, 64'd9, 64'd9, 64'd9, 1'b0, 1, 2);
    issue(4'b1001, 1'b1, 5'd18, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000,
          64'h4000_0000_0000_0000, 1'b0, 2, 130);
`else
    issue(4'b1001, 1'b1, 5'd13, 64'd48, 64'd18, 64'd0, 1'b1, 1, 1);
`endif
    drain();

    // Backpressure: result held 5 cycles while the next op waits
    bp_hold = 5;
    issue(4'b0010, 1'b1, 5'd20, 64'd2, 64'd3, 64'd5, 1'b0, 1, 1);
    issue(4'b0111, 1'b0, 5'd21, 64'hAA, 64'h0F, 64'hA5, 1'b0, 1, 1);
    drain();

    // Reset in the middle of a multiply
    issue(4'b0110, 1'b1, 5'd22, 64'd5, 64'd7, 64'd35, 1'b0, 65, 65);
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_rd", rd_out, 0);
    if (q.size() > 0) q.delete(q.size() - 1);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check("abort_no_output", seen, 0);

    issue(4'b0010, 1'b1, 5'd23, 64'd7, 64'd8, 64'd15, 1'b0, 1, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
